rs232_rx_ctrl: RTL and testbench
================================

RS232_RX_CTRL -- requirements
Module: rs232_rx_ctrl

Interface
REQ-001 Parameter DEPTH, default 16: receive FIFO entries; power of two, 4..256.
REQ-002 Parameter THRESH, default 8: fill level at which irq asserts; 1..DEPTH.
REQ-003 Parameter GAP, default 4000: idle clock cycles after the last captured byte before gap asserts; 1..65535.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rx_rdy  in  1  byte-ready from the RS232 receiver; level-high, held until acknowledged.
REQ-007 rx_data  in  8  received byte; valid while rx_rdy=1.
REQ-008 rx_done  out  1  acknowledge to the receiver; one-cycle pulse, registered.
REQ-009 rd  in  1  consumer pop strobe; one byte per cycle.
REQ-010 rd_data  out  8  FIFO head, show-ahead; valid while avail=1.
REQ-011 avail  out  1  FIFO non-empty.
REQ-012 count  out  clog2(DEPTH)+1  current FIFO fill level.
REQ-013 ovr  out  1  sticky overrun flag.
REQ-014 ovr_clr  in  1  clears ovr.
REQ-015 gap  out  1  line idle for GAP cycles with data pending.
REQ-016 irq  out  1  interrupt request, registered.

Function
REQ-017 Handshake FSM states: IDLE, ACK, WAIT.
REQ-018 IDLE: rx_rdy=1 -> capture rx_data this cycle, go to ACK; else stay.
REQ-019 ACK: rx_done=1 for exactly this cycle; go to WAIT unconditionally.
REQ-020 WAIT: rx_rdy=0 -> IDLE; rx_rdy=1 -> stay, no capture, rx_done=0.
REQ-021 rx_done=1 only in ACK; each received byte is captured exactly once.
REQ-022 Capture when count<DEPTH -> push, count+1 on the next edge.
REQ-023 Capture when count=DEPTH and rd=0 -> byte dropped, ovr set next edge, FIFO unchanged; handshake still completes.
REQ-024 Capture and rd in the same cycle -> push and pop both occur, count unchanged, including when full (no overrun).
REQ-025 rd with count=0 -> ignored, no pointer or count change.
REQ-026 rd with count>0 -> head advances next edge; rd_data shows the new head in the same cycle.
REQ-027 Pointers wrap modulo DEPTH; count never exceeds DEPTH and never goes below 0.
REQ-028 ovr_clr=1 clears ovr; an overrun in the same cycle as ovr_clr takes priority, so ovr=1.
REQ-029 Gap counter, 16 bits: zeroed on every capture; otherwise increments and saturates at GAP.
REQ-030 gap=1 when the gap counter equals GAP and count>0; gap=0 otherwise; gap drops in the cycle the FIFO empties.
REQ-031 irq registered as (count>=THRESH) | gap | ovr, one cycle after its inputs.

Reset
REQ-032 While rst=1 the following hold on every edge: FSM in IDLE; rx_done=0; count=0; avail=0; pointers=0; ovr=0; gap counter=0; gap=0; irq=0.
REQ-033 rd_data is don't-care while count=0; FIFO storage is not cleared.
REQ-034 Reset mid-handshake (ACK or WAIT) abandons the byte; if rx_rdy=1 after reset, the byte is captured fresh from IDLE.

Structure
REQ-035 Shared package rs232_pkg holds the FSM state encoding and the default DEPTH, THRESH and GAP constants.
REQ-036 One sub-module, rs232_fifo: synchronous show-ahead FIFO with push, pop, full, empty and count.
REQ-037 Handshake FSM, overrun, gap and irq logic live in rs232_rx_ctrl.
REQ-038 No combinational path from rx_rdy to rx_done.

Verification
REQ-039 Single byte: rx_rdy=1, rx_data=0x5A at cycle N -> rx_done=1 at N+1 only; avail=1 and rd_data=0x5A at N+1; rx_rdy dropped at N+2 -> IDLE at N+3.
REQ-040 Stuck rx_rdy: rx_rdy held high for 10 cycles -> exactly one push, one rx_done pulse, count=1.
REQ-041 Overflow: 17 bytes 0x00..0x10 with no reads (DEPTH=16) -> count=16, ovr=1, irq=1, reads return 0x00..0x0F; ovr_clr -> ovr=0.
REQ-042 Full plus simultaneous read: FIFO full, capture 0xAA with rd=1 -> count stays 16, ovr=0, 0xAA appears at the tail.
REQ-043 Gap: one byte, then GAP=20 idle cycles -> gap=1 exactly 20 cycles after the capture, irq=1 next cycle; rd -> gap=0.
REQ-044 Reset in WAIT with rx_rdy=1 -> all outputs at reset values; after rst falls, the byte is recaptured and rx_done pulses once.

Source files
------------

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared definitions for the RS232 receive controller.
//   rx_state_t  - handshake FSM state encoding
//   DEF_DEPTH   - default receive FIFO depth (entries)
//   DEF_THRESH  - default fill level that raises irq
//   DEF_GAP     - default idle cycles before the gap flag asserts
package rs232_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } rx_state_t;

  localparam int unsigned DEF_DEPTH  = 16;
  localparam int unsigned DEF_THRESH = 8;
  localparam int unsigned DEF_GAP    = 4000;

endpackage

// File: rtl/rs232_fifo.sv
// rs232_fifo: synchronous show-ahead byte FIFO.
//   clk, rst    - clock, synchronous active-high reset (pointers/count only)
//   push, din   - write request and data; accepted when not full or when
//                 a pop occurs in the same cycle
//   pop         - read request; ignored while empty
//   dout        - current head (valid while !empty)
//   full, empty - status flags
//   count       - fill level, 0..DEPTH
module rs232_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts
  // a push when it is read simultaneously.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/rs232_rx_ctrl.sv
// rs232_rx_ctrl: receive-side controller between an RS232 receiver and a
// byte consumer. Handshakes each received byte exactly once, buffers it in
// a FIFO, and reports overrun, line-idle gap and an interrupt.
//   clk, rst       - clock, synchronous active-high reset
//   rx_rdy, rx_data- byte-ready level and data from the receiver
//   rx_done        - registered one-cycle acknowledge to the receiver
//   rd             - consumer pop strobe
//   rd_data, avail - FIFO head (show-ahead) and non-empty flag
//   count          - FIFO fill level
//   ovr, ovr_clr   - sticky overrun flag and its clear
//   gap            - line idle GAP cycles with data still pending
//   irq            - registered (count>=THRESH) | gap | ovr
module rs232_rx_ctrl
  import rs232_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned THRESH = DEF_THRESH,
  parameter int unsigned GAP    = DEF_GAP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   rx_done,
  input  logic                   rd,
  output logic [7:0]             rd_data,
  output logic                   avail,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovr,
  input  logic                   ovr_clr,
  output logic                   gap,
  output logic                   irq
);

  localparam int unsigned      CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    THRESH_C = CW'(THRESH);
  localparam logic [15:0]      GAP_C    = 16'(GAP);
  localparam logic [15:0]      GCNT_ONE = 16'(1);

  rx_state_t   state;
  logic        capture;
  logic        overrun;
  logic        full;
  logic        empty;
  logic [15:0] gcnt;

  // A byte is taken only on the IDLE->ACK transition; the FIFO decides
  // whether it lands (room, or a simultaneous pop) or is dropped.
  always_comb begin
    capture = !rst && (state == ST_IDLE) && rx_rdy;
    overrun = capture && full && !rd;
  end

  rs232_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (rd),
    .din   (rx_data),
    .dout  (rd_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign avail = !empty;
  // Combinational on count so gap falls in the same cycle the FIFO empties.
  assign gap   = (gcnt == GAP_C) && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_rdy) begin
            state   <= ST_ACK;
            rx_done <= 1'b1;
          end
        end
        ST_ACK:  state <= ST_WAIT;
        ST_WAIT: if (!rx_rdy) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      gcnt <= '0;
      irq  <= 1'b0;
    end else begin
      // Overrun wins over a same-cycle clear.
      if (overrun)      ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;

      if (capture)            gcnt <= '0;
      else if (gcnt != GAP_C) gcnt <= gcnt + GCNT_ONE;

      irq <= (count >= THRESH_C) || gap || ovr;
    end
  end

endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// tb_rs232_rx_ctrl: randomized self-checking bench for rs232_rx_ctrl.
// A well-behaved receiver model presents bytes (holding rx_rdy through the
// acknowledge), and a queue-based reference predicts every output per cycle.
module tb_rs232_rx_ctrl;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;
  localparam int unsigned GAP    = 20;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_done;
  logic          rd = 1'b0;
  logic [7:0]    rd_data;
  logic          avail;
  logic [CW-1:0] count;
  logic          ovr;
  logic          ovr_clr = 1'b0;
  logic          gap;
  logic          irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: byte queue plus flags, in protocol terms.
  logic [7:0]  q[$];
  bit          m_ovr;
  bit          m_irq;
  bit          m_done;
  bit          m_capd;   // current presentation already taken
  int unsigned m_since;  // edges since the last capture

  rs232_rx_ctrl #(.DEPTH(DEPTH), .THRESH(THRESH), .GAP(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_rdy  (rx_rdy),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rd      (rd),
    .rd_data (rd_data),
    .avail   (avail),
    .count   (count),
    .ovr     (ovr),
    .ovr_clr (ovr_clr),
    .gap     (gap),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the reference, then compare outputs.
  task automatic cycle(input bit r, input bit rx, input logic [7:0] d,
                       input bit rdi, input bit clr);
    bit cap;
    bit ovf;
    bit g;
    rst = r; rx_rdy = rx; rx_data = d; rd = rdi; ovr_clr = clr;
    cap = rx && !r && !m_capd;
    if (r) begin
      q.delete();
      m_ovr = 0; m_irq = 0; m_done = 0; m_since = 0; m_capd = 0;
    end else begin
      g     = (m_since >= GAP) && (q.size() > 0);
      m_irq = (q.size() >= THRESH) || g || m_ovr;
      ovf   = cap && (q.size() == DEPTH) && !rdi;
      if (rdi && q.size() > 0) void'(q.pop_front());
      if (cap && !ovf) q.push_back(d);
      m_ovr   = ovf || (m_ovr && !clr);
      m_since = cap ? 0 : ((m_since < 100000) ? m_since + 1 : m_since);
      m_done  = cap;
      m_capd  = rx && (m_capd || cap);
    end
    @(posedge clk);
    #1;
    chk("count",   32'(count),   32'(q.size()));
    chk("avail",   32'(avail),   32'(q.size() > 0));
    if (q.size() > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
    chk("rx_done", 32'(rx_done), 32'(m_done));
    chk("ovr",     32'(ovr),     32'(m_ovr));
    chk("gap",     32'(gap),     32'((m_since >= GAP) && (q.size() > 0)));
    chk("irq",     32'(irq),     32'(m_irq));
  endtask

  function automatic bit pct(input int unsigned p);
    return $urandom_range(99) < p;
  endfunction

  // One byte presentation: rise (capture), hold >=1 more cycle so the
  // acknowledge is seen, then drop for 'low' cycles.
  task automatic send_byte(input logic [7:0] d, input int unsigned hold,
                           input int unsigned low, input int unsigned rdp,
                           input bit rdcap, input int unsigned clrp);
    cycle(0, 1, d, rdcap || pct(rdp), pct(clrp));
    for (int unsigned i = 0; i < hold; i++) cycle(0, 1, d, pct(rdp), pct(clrp));
    for (int unsigned i = 0; i < low; i++)  cycle(0, 0, 8'h00, pct(rdp), pct(clrp));
  endtask

  task automatic do_reset();
    cycle(1, 0, 8'h00, 0, 0);
    cycle(1, 0, 8'h00, 0, 0);
  endtask

  task automatic idle(input int unsigned n, input bit rdi);
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 8'h00, rdi, 0);
  endtask

  initial begin
    do_reset();

    // Single byte, then drain.
    send_byte(8'h5A, 1, 1, 0, 0, 0);
    idle(1, 1);

    // rx_rdy held high 10 cycles: one capture only.
    send_byte(8'h3C, 10, 2, 0, 0, 0);
    idle(2, 1);

    // Overflow with no reads, drain in order, then clear overrun.
    do_reset();
    for (int unsigned i = 0; i < 17; i++) send_byte(8'(i), 1, 1, 0, 0, 0);
    idle(16, 1);
    cycle(0, 0, 8'h00, 0, 1);
    idle(2, 0);

    // Full FIFO plus capture with simultaneous read.
    do_reset();
    for (int unsigned i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 1, 1, 0, 0, 0);
    send_byte(8'hAA, 1, 1, 0, 1, 0);
    idle(16, 1);

    // Gap: one byte, long idle, then read empties the FIFO.
    do_reset();
    send_byte(8'h77, 1, 25, 0, 0, 0);
    idle(3, 1);

    // Reset while in WAIT with rx_rdy high: byte recaptured afterwards.
    do_reset();
    cycle(0, 1, 8'h99, 0, 0);
    cycle(0, 1, 8'h99, 0, 0);
    cycle(0, 1, 8'h99, 0, 0);
    cycle(1, 1, 8'h99, 0, 0);
    cycle(1, 1, 8'h99, 0, 0);
    cycle(0, 1, 8'h99, 0, 0);
    cycle(0, 1, 8'h99, 0, 0);
    cycle(0, 0, 8'h00, 0, 0);
    idle(2, 1);

    // Randomized traffic: light reads (overruns likely), then heavy reads.
    do_reset();
    for (int unsigned ph = 0; ph < 2; ph++) begin
      for (int unsigned n = 0; n < 150; n++) begin
        int unsigned low;
        low = ($urandom_range(9) == 0) ? $urandom_range(30, 20) : $urandom_range(3, 1);
        send_byte(8'($urandom_range(255)), $urandom_range(4, 1), low,
                  (ph == 0) ? 15 : 70, 1'b0, 5);
      end
    end
    idle(20, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
